ecc_scrub_ctrl: RTL and testbench

Background scrubber for the Hamming-protected (38-bit codeword, 32 data + 6 parity) register storage of the core. It periodically walks every entry, decodes the stored codeword, and writes back the re-encoded value when a single-bit error is found. Storage port access is requested through a req/gnt handshake, and the core always has priority. It counts corrected errors and flags uncorrectable syndromes to the trap/status logic.

---
 rtl/ecc_pkg.sv | 43 ++++
 rtl/ecc38_correct.sv | 30 +++
 rtl/ecc_scrub_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ecc_scrub_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared ECC widths, scrubber state encoding and the Hamming(38,32) encoder.
package ecc_pkg;

    localparam int unsigned ECC_DW = 32;
    localparam int unsigned ECC_PW = 6;
    localparam int unsigned ECC_CW = 38;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RD,
        CAP,
        CHK,
        WR,
        NEXT
    } scrub_state_t;

    // Codeword bit i is Hamming position i+1; parity at power-of-two positions.
    function automatic logic [ECC_CW-1:0] ecc_encode32(input logic [ECC_DW-1:0] data);
        logic [ECC_CW-1:0] cw;
        int unsigned       j;
        logic              par;
        cw = '0;
        j  = 0;
        for (int unsigned i = 0; i < ECC_CW; i++) begin
            if (((i + 1) & i) != 0) begin
                cw[6'(i)] = data[5'(j)];
                j++;
            end
        end
        for (int unsigned k = 0; k < ECC_PW; k++) begin
            par = 1'b0;
            for (int unsigned i = 0; i < ECC_CW; i++) begin
                if ((((i + 1) >> k) & 1) != 0) begin
                    par = par ^ cw[6'(i)];
                end
            end
            cw[6'((1 << k) - 1)] = par;
        end
        return cw;
    endfunction

endpackage

// File: rtl/ecc38_correct.sv
// Combinational Hamming(38,32) syndrome decode and single-bit correction.
module ecc38_correct
    import ecc_pkg::*;
(
    input  logic [ECC_CW-1:0] codeword,
    output logic [ECC_PW-1:0] syndrome,
    output logic [ECC_CW-1:0] corrected,
    output logic              correctable,
    output logic              uncorrectable
);

    // Syndrome bit k covers every position with bit k set.
    always_comb begin
        syndrome = '0;
        for (int unsigned k = 0; k < ECC_PW; k++) begin
            for (int unsigned i = 0; i < ECC_CW; i++) begin
                if ((((i + 1) >> k) & 1) != 0) begin
                    syndrome[3'(k)] = syndrome[3'(k)] ^ codeword[6'(i)];
                end
            end
        end
    end

    // Syndromes past the last position cannot point at a single bad bit.
    assign correctable   = (syndrome != '0) && (syndrome <= 6'(ECC_CW));
    assign uncorrectable = (syndrome > 6'(ECC_CW));
    assign corrected     = correctable ? (codeword ^ (ECC_CW'(1) << (syndrome - 6'd1)))
                                       : codeword;

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background scrubber: walks every entry, corrects single-bit errors in place,
// counts corrections and latches the first uncorrectable address.
module ecc_scrub_ctrl
    import ecc_pkg::*;
#(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned INTERVAL = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [ECC_CW-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic [ECC_CW-1:0] mem_rdata,
    input  logic              core_wr,
    input  logic [AW-1:0]     core_wr_addr,
    output logic [15:0]       err_count,
    output logic              uncorr,
    output logic [AW-1:0]     uncorr_addr,
    output logic              pass_done,
    output logic              busy
);

    localparam int unsigned       CNT_W     = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(INTERVAL - 1);
    localparam logic [AW-1:0]     LAST_ADDR = AW'(DEPTH - 1);

    scrub_state_t      state;
    scrub_state_t      next_state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_d;
    logic [ECC_CW-1:0] cw_q;
    logic              hazard_q;
    logic              hazard_d;
    logic              core_hit;

    logic [ECC_PW-1:0] syndrome;
    logic [ECC_CW-1:0] corrected;
    logic              correctable;
    logic              uncorrectable;

    logic              mem_req_d;
    logic              mem_we_d;
    logic [AW-1:0]     mem_addr_d;
    logic [ECC_CW-1:0] mem_wdata_d;
    logic [15:0]       err_count_d;
    logic              uncorr_d;
    logic [AW-1:0]     uncorr_addr_d;
    logic              pass_done_d;
    logic              busy_d;

    ecc38_correct u_correct (
        .codeword      (cw_q),
        .syndrome      (syndrome),
        .corrected     (corrected),
        .correctable   (correctable),
        .uncorrectable (uncorrectable)
    );

    // A core write to the entry being scrubbed makes our write-back stale.
    assign core_hit = core_wr && (core_wr_addr == mem_addr);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a core hit beats a simultaneous write grant.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (enable) next_state = WAIT;
            WAIT: if (cnt == CNT_LAST) next_state = RD;
            RD:   if (mem_gnt) next_state = CAP;
            CAP:  next_state = CHK;
            CHK: begin
                if ((syndrome == '0) || uncorrectable || hazard_q || core_hit) begin
                    next_state = NEXT;
                end else begin
                    next_state = WR;
                end
            end
            WR:   if (core_hit || mem_gnt) next_state = NEXT;
            NEXT: next_state = enable ? WAIT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath.
    always_comb begin
        mem_req_d     = (next_state == RD) || (next_state == WR);
        mem_we_d      = (next_state == WR);
        busy_d        = (next_state != IDLE) && (next_state != WAIT);
        mem_wdata_d   = mem_wdata;
        mem_addr_d    = mem_addr;
        pass_done_d   = 1'b0;
        err_count_d   = err_count;
        uncorr_d      = uncorr;
        uncorr_addr_d = uncorr_addr;
        cnt_d         = '0;
        hazard_d      = (state == CAP) && core_hit;

        if ((state == WAIT) && (cnt != CNT_LAST)) begin
            cnt_d = cnt + CNT_W'(1);
        end
        if ((state == CHK) && (next_state == WR)) begin
            mem_wdata_d = corrected;
        end
        if ((state == CHK) && correctable && (err_count != 16'hFFFF)) begin
            err_count_d = err_count + 16'd1;
        end
        if ((state == CHK) && uncorrectable) begin
            uncorr_d = 1'b1;
            if (!uncorr) begin
                uncorr_addr_d = mem_addr;
            end
        end
        if (state == NEXT) begin
            mem_addr_d  = (mem_addr == LAST_ADDR) ? '0 : mem_addr + AW'(1);
            pass_done_d = (mem_addr == LAST_ADDR);
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            err_count   <= '0;
            uncorr      <= 1'b0;
            uncorr_addr <= '0;
            pass_done   <= 1'b0;
            busy        <= 1'b0;
            cnt         <= '0;
            hazard_q    <= 1'b0;
            cw_q        <= '0;
        end else begin
            mem_req     <= mem_req_d;
            mem_we      <= mem_we_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            err_count   <= err_count_d;
            uncorr      <= uncorr_d;
            uncorr_addr <= uncorr_addr_d;
            pass_done   <= pass_done_d;
            busy        <= busy_d;
            cnt         <= cnt_d;
            hazard_q    <= hazard_d;
            if (state == CAP) begin
                cw_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl with a small granting storage model.
module tb_ecc_scrub_ctrl;
    import ecc_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned AW       = 2;
    localparam int unsigned INTERVAL = 2;
    localparam int          LIMIT    = 500;

    // Hand-encoded Hamming codeword of 32'hA5A5_0F0F.
    localparam logic [37:0] CLEAN = 38'h29_B4A1_70FF;
    localparam logic [37:0] ALL1  = 38'h3F_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          resetn;
    logic          enable;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [37:0]   mem_wdata;
    logic          mem_gnt;
    logic [37:0]   mem_rdata;
    logic          core_wr;
    logic [AW-1:0] core_wr_addr;
    logic [15:0]   err_count;
    logic          uncorr;
    logic [AW-1:0] uncorr_addr;
    logic          pass_done;
    logic          busy;

    logic          gnt_allow;
    logic          poke_en;
    logic [AW-1:0] poke_addr;
    logic [37:0]   poke_data;
    logic [37:0]   mem [DEPTH];
    int            rd_cnt = 0;
    int            wr_cnt = 0;
    int            pass_cnt = 0;
    logic [AW-1:0] last_wa;
    logic [37:0]   last_wd;

    int checks = 0;
    int errors = 0;

    int rd0;
    int wr0;
    int ps0;

    always #5 clk = ~clk;

    assign mem_gnt = mem_req & gnt_allow;

    ecc_scrub_ctrl #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .INTERVAL (INTERVAL)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .enable       (enable),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rdata    (mem_rdata),
        .core_wr      (core_wr),
        .core_wr_addr (core_wr_addr),
        .err_count    (err_count),
        .uncorr       (uncorr),
        .uncorr_addr  (uncorr_addr),
        .pass_done    (pass_done),
        .busy         (busy)
    );

    // Storage model: read data one cycle after grant, writes logged.
    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end
        if (mem_req && mem_gnt) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                wr_cnt  <= wr_cnt + 1;
                last_wa <= mem_addr;
                last_wd <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr];
                rd_cnt    <= rd_cnt + 1;
            end
        end
        if (pass_done) begin
            pass_cnt <= pass_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [37:0] d);
        @(negedge clk);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || mem_req) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 64'(n < LIMIT), 64'(1));
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_read();
        int n;
        n = 0;
        while (!(mem_req && !mem_we) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("read_timeout", 64'(n < LIMIT), 64'(1));
    endtask

    task automatic wait_write();
        int n;
        n = 0;
        while (!(mem_req && mem_we) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("write_timeout", 64'(n < LIMIT), 64'(1));
    endtask

    // Scrub n words, dropping enable inside the last one.
    task automatic scrub(input int n);
        int tgt;
        int cyc;
        tgt = rd_cnt + n;
        cyc = 0;
        enable = 1'b1;
        while (rd_cnt < tgt && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check("scrub_timeout", 64'(rd_cnt >= tgt), 64'(1));
        enable = 1'b0;
        wait_idle();
    endtask

    task automatic mark();
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        ps0 = pass_cnt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn       = 1'b0;
        enable       = 1'b0;
        core_wr      = 1'b0;
        core_wr_addr = '0;
        gnt_allow    = 1'b1;
        poke_en      = 1'b0;
        poke_addr    = '0;
        poke_data    = '0;
        repeat (3) @(negedge clk);

        check("rst_req",   64'(mem_req),   64'(0));
        check("rst_addr",  64'(mem_addr),  64'(0));
        check("rst_wdata", 64'(mem_wdata), 64'(0));
        check("rst_err",   64'(err_count), 64'(0));
        check("rst_busy",  64'(busy),      64'(0));
        resetn = 1'b1;

        check("encode", 64'(ecc_encode32(32'hA5A5_0F0F)), 64'(CLEAN));
        for (int i = 0; i < DEPTH; i++) poke(AW'(i), CLEAN);

        // Clean sweep of all four entries.
        mark();
        scrub(4);
        check("clean_reads",  64'(rd_cnt - rd0),   64'(4));
        check("clean_writes", 64'(wr_cnt - wr0),   64'(0));
        check("clean_pass",   64'(pass_cnt - ps0), 64'(1));
        check("clean_err",    64'(err_count),      64'(0));
        check("clean_addr",   64'(mem_addr),       64'(0));

        // Single-bit error at entry 2, codeword bit 9 (syndrome 10).
        poke(2'd2, CLEAN ^ (38'(1) << 9));
        mark();
        scrub(4);
        check("sbe_writes", 64'(wr_cnt - wr0), 64'(1));
        check("sbe_waddr",  64'(last_wa),      64'(2));
        check("sbe_wdata",  64'(last_wd),      64'(CLEAN));
        check("sbe_mem",    64'(mem[2]),       64'(CLEAN));
        check("sbe_err",    64'(err_count),    64'(1));

        // Uncorrectable at entry 1, then another at entry 3.
        poke(2'd1, ALL1);
        mark();
        scrub(4);
        check("ue_writes", 64'(wr_cnt - wr0), 64'(0));
        check("ue_flag",   64'(uncorr),       64'(1));
        check("ue_addr",   64'(uncorr_addr),  64'(1));
        check("ue_err",    64'(err_count),    64'(1));
        poke(2'd1, CLEAN);
        poke(2'd3, ALL1);
        scrub(4);
        check("ue2_flag", 64'(uncorr),      64'(1));
        check("ue2_addr", 64'(uncorr_addr), 64'(1));

        // Core write to entry 0 during CAP cancels the write-back.
        poke(2'd0, CLEAN ^ 38'(1));
        mark();
        enable = 1'b1;
        wait_read();
        @(negedge clk);
        core_wr      = 1'b1;
        core_wr_addr = 2'd0;
        enable       = 1'b0;
        @(negedge clk);
        core_wr      = 1'b0;
        wait_idle();
        check("hz_reads",  64'(rd_cnt - rd0), 64'(1));
        check("hz_writes", 64'(wr_cnt - wr0), 64'(0));
        check("hz_err",    64'(err_count),    64'(2));
        check("hz_addr",   64'(mem_addr),     64'(1));
        check("hz_mem",    64'(mem[0]),       64'(CLEAN ^ 38'(1)));

        // Back-pressured read, then enable dropped while the write is pending.
        poke(2'd1, CLEAN ^ (38'(1) << 20));
        mark();
        gnt_allow = 1'b0;
        enable    = 1'b1;
        wait_read();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_req",  64'(mem_req && !mem_we), 64'(1));
            check("bp_addr", 64'(mem_addr),           64'(1));
        end
        check("bp_noread", 64'(rd_cnt - rd0), 64'(0));
        gnt_allow = 1'b1;
        @(negedge clk);
        gnt_allow = 1'b0;
        wait_write();
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("wr_hold",  64'(mem_req && mem_we), 64'(1));
        check("wr_wdata", 64'(mem_wdata),         64'(CLEAN));
        gnt_allow = 1'b1;
        wait_idle();
        check("dis_writes", 64'(wr_cnt - wr0), 64'(1));
        check("dis_waddr",  64'(last_wa),      64'(1));
        check("dis_mem",    64'(mem[1]),       64'(CLEAN));
        check("dis_err",    64'(err_count),    64'(3));
        check("dis_addr",   64'(mem_addr),     64'(2));
        check("dis_idle",   64'(busy || mem_req), 64'(0));

        // Reset asserted while a write-back is waiting for its grant.
        poke(2'd2, CLEAN ^ (38'(1) << 5));
        mark();
        enable = 1'b1;
        wait_read();
        @(negedge clk);
        gnt_allow = 1'b0;
        wait_write();
        enable = 1'b0;
        resetn = 1'b0;
        #1;
        check("mid_rst_req",   64'(mem_req),     64'(0));
        check("mid_rst_we",    64'(mem_we),      64'(0));
        check("mid_rst_addr",  64'(mem_addr),    64'(0));
        check("mid_rst_wdata", 64'(mem_wdata),   64'(0));
        check("mid_rst_err",   64'(err_count),   64'(0));
        check("mid_rst_uc",    64'(uncorr),      64'(0));
        check("mid_rst_uca",   64'(uncorr_addr), 64'(0));
        check("mid_rst_pass",  64'(pass_done),   64'(0));
        check("mid_rst_busy",  64'(busy),        64'(0));
        @(negedge clk);
        resetn    = 1'b1;
        gnt_allow = 1'b1;
        check("mid_rst_nowr", 64'(wr_cnt - wr0), 64'(0));

        // Counter saturation: preload all-ones, then correct entry 0.
        @(negedge clk);
        force dut.err_count = 16'hFFFF;
        @(negedge clk);
        release dut.err_count;
        @(negedge clk);
        check("sat_preload", 64'(err_count), 64'hFFFF);
        mark();
        scrub(1);
        check("sat_err",    64'(err_count),    64'hFFFF);
        check("sat_writes", 64'(wr_cnt - wr0), 64'(1));
        check("sat_mem",    64'(mem[0]),       64'(CLEAN));
        check("sat_addr",   64'(mem_addr),     64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
